// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, registered syncs, decoded
// visible-area and end-of-line/frame strobes, and a completed-frame counter.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_end,
    output logic       frame_end,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Window bounds can reach 1024, so they are compared one bit wider than x/y.
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       hs_next;
    logic       vs_next;

    always_comb begin
        line_end   = (x == H_LAST);
        frame_end  = line_end && (y == V_LAST);
        display_on = ({1'b0, x} < H_VIS) && ({1'b0, y} < V_VIS);

        x_next = line_end ? '0 : x + 10'd1;
        y_next = y;
        if (line_end) begin
            y_next = (y == V_LAST) ? '0 : y + 10'd1;
        end

        // Syncs are registered from the next coordinates so they line up with x/y.
        hs_next = ({1'b0, x_next} >= HS_START) && ({1'b0, x_next} < HS_END);
        vs_next = ({1'b0, y_next} >= VS_START) && ({1'b0, y_next} < VS_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_count <= '0;
        end else if (ena) begin
            x     <= x_next;
            y     <= y_next;
            hsync <= hs_next ? SYNC_POL : ~SYNC_POL;
            vsync <= vs_next ? SYNC_POL : ~SYNC_POL;
            if (frame_end) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default 640x480 instance and a tiny 12x7 instance run side by side.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Default-parameter instance
    logic       rst_d = 1'b0, ena_d = 1'b0;
    logic [9:0] x_d, y_d;
    logic       hs_d, vs_d, don_d, le_d, fe_d;
    logic [7:0] fc_d;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(rst_d), .ena(ena_d), .x(x_d), .y(y_d),
        .hsync(hs_d), .vsync(vs_d), .display_on(don_d), .line_end(le_d),
        .frame_end(fe_d), .frame_count(fc_d)
    );

    // Small instance: H_TOTAL=12, V_TOTAL=7, active-high syncs
    logic       rst_s = 1'b0, ena_s = 1'b0;
    logic [9:0] x_s, y_s;
    logic       hs_s, vs_s, don_s, le_s, fe_s;
    logic [7:0] fc_s;

    vga_timing_gen #(
        .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst_n(rst_s), .ena(ena_s), .x(x_s), .y(y_s),
        .hsync(hs_s), .vsync(vs_s), .display_on(don_s), .line_end(le_s),
        .frame_end(fe_s), .frame_count(fc_s)
    );

    // Expected coordinates of the default instance
    int unsigned dx = 0, dy = 0;

    task automatic run_def(input int unsigned n, input bit full);
        for (int unsigned i = 0; i < n; i++) begin
            ena_d = 1'b1;
            @(negedge clk);
            if (dx == 799) begin
                dx = 0;
                dy = (dy == 524) ? 0 : dy + 1;
            end else begin
                dx = dx + 1;
            end
            if (full) begin
                check("d_x", x_d, dx);
                check("d_y", y_d, dy);
                check("d_hsync", hs_d, (dx >= 656 && dx <= 751) ? 0 : 1);
                check("d_vsync", vs_d, 1);
                check("d_display_on", don_d, (dx < 640 && dy < 480) ? 1 : 0);
                check("d_line_end", le_d, (dx == 799) ? 1 : 0);
                check("d_frame_end", fe_d, 0);
                check("d_frame_count", fc_d, 0);
            end
        end
    endtask

    // Expected state of the small instance
    int unsigned sx = 0, sy = 0, sfc = 0, slen = 0;

    task automatic run_small(input int unsigned n, input bit gate);
        for (int unsigned i = 0; i < n; i++) begin
            ena_s = gate ? (i % 4 == 0) : 1'b1;
            @(negedge clk);
            if (ena_s) begin
                slen++;
                if (sx == 11) begin
                    sx = 0;
                    if (sy == 6) begin
                        sy = 0;
                        sfc = (sfc + 1) % 256;
                        check("s_frame_len", slen, 84);
                        slen = 0;
                    end else begin
                        sy = sy + 1;
                    end
                end else begin
                    sx = sx + 1;
                end
            end
            check("s_x", x_s, sx);
            check("s_y", y_s, sy);
            check("s_hsync", hs_s, (sx >= 9 && sx <= 10) ? 1 : 0);
            check("s_vsync", vs_s, (sy == 5) ? 1 : 0);
            check("s_display_on", don_s, (sx < 8 && sy < 4) ? 1 : 0);
            check("s_line_end", le_s, (sx == 11) ? 1 : 0);
            check("s_frame_end", fe_s, (sx == 11 && sy == 6) ? 1 : 0);
            check("s_frame_count", fc_s, sfc);
        end
    endtask

    initial begin
        fork
            begin : default_path
                @(negedge clk);
                check("d_rst_x", x_d, 0);
                check("d_rst_y", y_d, 0);
                check("d_rst_hsync", hs_d, 1);
                check("d_rst_vsync", vs_d, 1);
                check("d_rst_display_on", don_d, 1);
                check("d_rst_line_end", le_d, 0);
                check("d_rst_frame_end", fe_d, 0);
                check("d_rst_frame_count", fc_d, 0);
                rst_d = 1'b1;
                // Two full lines plus a little, then fast-forward to (300,100).
                run_def(1700, 1'b1);
                run_def(100 * 800 + 300 - 1700, 1'b0);
                check("d_pos_x", x_d, 300);
                check("d_pos_y", y_d, 100);
                ena_d = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("d_hold_x", x_d, 300);
                    check("d_hold_y", y_d, 100);
                end
                #2 rst_d = 1'b0;
                #1;
                check("d_arst_x", x_d, 0);
                check("d_arst_y", y_d, 0);
                check("d_arst_hsync", hs_d, 1);
                check("d_arst_vsync", vs_d, 1);
                check("d_arst_display_on", don_d, 1);
                check("d_arst_frame_count", fc_d, 0);
                @(negedge clk);
                rst_d = 1'b1;
                dx = 0;
                dy = 0;
                run_def(5, 1'b1);
                check("d_resume_x", x_d, 5);
            end
            begin : small_path
                @(negedge clk);
                check("s_rst_x", x_s, 0);
                check("s_rst_y", y_s, 0);
                check("s_rst_hsync", hs_s, 0);
                check("s_rst_vsync", vs_s, 0);
                check("s_rst_display_on", don_s, 1);
                check("s_rst_frame_count", fc_s, 0);
                rst_s = 1'b1;
                run_small(84, 1'b0);
                check("s_first_wrap_count", fc_s, 1);
                run_small(256 * 84, 1'b0);
                check("s_257_frames_count", fc_s, 1);
                check("s_257_frames_x", x_s, 0);
                // Enable 1-of-4: frame length still counts 84 enabled cycles.
                run_small(400, 1'b1);
                for (int i = 0; i < 200 && !(sx == 9 && sy == 5); i++) begin
                    run_small(1, 1'b0);
                end
                check("s_presync_hsync", hs_s, 1);
                check("s_presync_vsync", vs_s, 1);
                #2 rst_s = 1'b0;
                #1;
                check("s_arst_x", x_s, 0);
                check("s_arst_y", y_s, 0);
                check("s_arst_hsync", hs_s, 0);
                check("s_arst_vsync", vs_s, 0);
                check("s_arst_display_on", don_s, 1);
                check("s_arst_frame_count", fc_s, 0);
                @(negedge clk);
                rst_s = 1'b1;
                sx = 0;
                sy = 0;
                sfc = 0;
                slen = 0;
                run_small(30, 1'b0);
            end
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
